flags_rx_scheduler: RTL and testbench

Controller that owns the flags register file for the receive side of the photonic interface. It maps receiver arrival pulses onto flag set writes, polls the flags round-robin, and hands each set flag to the core as a service request. After the core acknowledges, it clears the flag (ready-to-receive). Because the flags file has no reset, the block also performs a clearing sweep of all entries after every reset.

---
 rtl/flags_sched_pkg.sv | 16 +
 rtl/flags_rx_scheduler.sv | 109 ++++++++++
 tb/tb_flags_rx_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flags_sched_pkg.sv
// Shared types for the receive-side flags scheduler: FSM state encoding and
// the channel-count derivation from the flag address width.
package flags_sched_pkg;

  typedef enum logic [1:0] {
    StInit,
    StScan,
    StGrant,
    StClear
  } state_e;

  function automatic int unsigned num_channels(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/flags_rx_scheduler.sv
// Receive-side flags controller: clears the reset-less flags file after reset, sets
// flags on arrivals, polls them round-robin and offers each set flag to the core.
module flags_rx_scheduler
  import flags_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_RF = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [ADDR_WIDTH_RF-1:0] rx_channel,
  output logic                     rx_ready,
  output logic                     flag_rx_write_enable,
  output logic [ADDR_WIDTH_RF-1:0] flag_address_1,
  output logic                     flag_rtr_write_enable,
  output logic [ADDR_WIDTH_RF-1:0] flag_address_2,
  output logic [ADDR_WIDTH_RF-1:0] flag_address_3,
  input  logic                     flag_read_data,
  output logic                     service_req,
  output logic [ADDR_WIDTH_RF-1:0] service_channel,
  input  logic                     service_ack,
  output logic                     init_done
);

  localparam int unsigned N = num_channels(ADDR_WIDTH_RF);
  localparam logic [ADDR_WIDTH_RF-1:0] LastCh = ADDR_WIDTH_RF'(N - 1);
  localparam logic [ADDR_WIDTH_RF-1:0] One    = ADDR_WIDTH_RF'(1);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH_RF-1:0] init_ptr_q, init_ptr_d;
  logic [ADDR_WIDTH_RF-1:0] poll_ptr_q, poll_ptr_d;
  logic [ADDR_WIDTH_RF-1:0] cur_q, cur_d;
  logic                     init_done_q, init_done_d;
  logic                     clear_conflict;

  // Receive path is purely combinational and gated only by sweep completion.
  assign rx_ready             = init_done_q;
  assign flag_rx_write_enable = rx_valid & rx_ready;
  assign flag_address_1       = rx_channel;
  assign flag_address_3       = poll_ptr_q;
  assign service_req          = (state_q == StGrant);
  assign service_channel      = cur_q;
  assign init_done            = init_done_q;

  // A fresh arrival on the channel being cleared must win over the clear.
  assign clear_conflict = flag_rx_write_enable && (rx_channel == cur_q);

  always_comb begin
    state_d               = state_q;
    init_ptr_d            = init_ptr_q;
    poll_ptr_d            = poll_ptr_q;
    cur_d                 = cur_q;
    init_done_d           = init_done_q;
    flag_rtr_write_enable = 1'b0;
    flag_address_2        = cur_q;

    unique case (state_q)
      StInit: begin
        flag_rtr_write_enable = ~reset;
        flag_address_2        = init_ptr_q;
        init_ptr_d            = init_ptr_q + One;
        if (init_ptr_q == LastCh) begin
          state_d     = StScan;
          init_done_d = 1'b1;
        end
      end
      StScan: begin
        if (flag_read_data) begin
          cur_d   = poll_ptr_q;
          state_d = StGrant;
        end else begin
          poll_ptr_d = poll_ptr_q + One;
        end
      end
      StGrant: begin
        if (service_ack) begin
          state_d = StClear;
        end
      end
      StClear: begin
        if (clear_conflict) begin
          state_d = StGrant;
        end else begin
          flag_rtr_write_enable = 1'b1;
          poll_ptr_d            = cur_q + One;
          state_d               = StScan;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      init_ptr_q  <= '0;
      poll_ptr_q  <= '0;
      cur_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      poll_ptr_q  <= poll_ptr_d;
      cur_q       <= cur_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

// File: tb/tb_flags_rx_scheduler.sv
// Bench for flags_rx_scheduler with a behavioural flags file, directed corner
// sequences and randomized arrivals/acks against a round-robin service model.
module tb_flags_rx_scheduler;

  localparam int AW = 2;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] rx_channel = '0;
  logic          rx_ready;
  logic          flag_rx_write_enable;
  logic [AW-1:0] flag_address_1;
  logic          flag_rtr_write_enable;
  logic [AW-1:0] flag_address_2;
  logic [AW-1:0] flag_address_3;
  logic          flag_read_data;
  logic          service_req;
  logic [AW-1:0] service_channel;
  logic          service_ack = 1'b0;
  logic          init_done;

  // Flags file: no reset, power-up contents deliberately all ones.
  logic [N-1:0]  rf = '1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (flag_rx_write_enable) rf[flag_address_1] <= 1'b1;
    if (flag_rtr_write_enable) rf[flag_address_2] <= 1'b0;
  end
  assign flag_read_data = rf[flag_address_3];

  flags_rx_scheduler #(.ADDR_WIDTH_RF(AW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .rx_valid              (rx_valid),
    .rx_channel            (rx_channel),
    .rx_ready              (rx_ready),
    .flag_rx_write_enable  (flag_rx_write_enable),
    .flag_address_1        (flag_address_1),
    .flag_rtr_write_enable (flag_rtr_write_enable),
    .flag_address_2        (flag_address_2),
    .flag_address_3        (flag_address_3),
    .flag_read_data        (flag_read_data),
    .service_req           (service_req),
    .service_channel       (service_channel),
    .service_ack           (service_ack),
    .init_done             (init_done)
  );

  typedef struct {
    bit          rx_valid;
    bit [AW-1:0] rx_channel;
    bit          rtr_we;
    bit [AW-1:0] addr2;
    bit          init_done;
    bit          rx_we;
  } init_vec_t;

  init_vec_t tv[5];

  // Service model: pending set plus the channel after the last one served.
  bit m_pend[N];
  int m_next = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!service_req && k < 12) begin
      tick();
      k++;
    end
    if (!service_req) check(name, 0, 1);
  endtask

  task automatic ack_once();
    service_ack = 1'b1;
    tick();
    service_ack = 1'b0;
  endtask

  task automatic arrive(input int ch);
    rx_valid   = 1'b1;
    rx_channel = AW'(ch);
    tick();
    rx_valid   = 1'b0;
  endtask

  function automatic int first_pending();
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m_next + k) % N;
      if (m_pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_ch, gch, idle_cyc, ch;
    bit  granted, just_acked, do_ack, do_rx;

    tv[0] = '{0, 0, 1, 0, 0, 0};
    tv[1] = '{1, 0, 1, 1, 0, 0};
    tv[2] = '{1, 0, 1, 2, 0, 0};
    tv[3] = '{0, 0, 1, 3, 0, 0};
    tv[4] = '{0, 0, 0, 0, 1, 0};

    // Reset held for three cycles.
    repeat (3) tick();
    check("reset_service_req", int'(service_req), 0);
    check("reset_rtr_we", int'(flag_rtr_write_enable), 0);
    check("reset_rx_ready", int'(rx_ready), 0);
    check("reset_init_done", int'(init_done), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      rx_valid   = tv[i].rx_valid;
      rx_channel = tv[i].rx_channel;
      #1;
      check($sformatf("init_rtr_we[%0d]", i), int'(flag_rtr_write_enable), int'(tv[i].rtr_we));
      if (tv[i].rtr_we)
        check($sformatf("init_addr2[%0d]", i), int'(flag_address_2), int'(tv[i].addr2));
      check($sformatf("init_done[%0d]", i), int'(init_done), int'(tv[i].init_done));
      check($sformatf("init_rx_ready[%0d]", i), int'(rx_ready), int'(tv[i].init_done));
      check($sformatf("init_rx_we[%0d]", i), int'(flag_rx_write_enable), int'(tv[i].rx_we));
      tick();
    end
    rx_valid = 1'b0;
    for (int c = 0; c < N; c++) check($sformatf("swept_flag[%0d]", c), int'(rf[c]), 0);

    // Single arrival, service and clear.
    rx_valid   = 1'b1;
    rx_channel = 2'd2;
    #1;
    check("rx_we_ch2", int'(flag_rx_write_enable), 1);
    tick();
    rx_valid = 1'b0;
    wait_req("wait_req_ch2");
    check("grant_ch2", int'(service_channel), 2);
    check("flag2_set", int'(rf[2]), 1);
    ack_once();
    check("clear_rtr_we_ch2", int'(flag_rtr_write_enable), 1);
    check("clear_addr2_ch2", int'(flag_address_2), 2);
    check("clear_req_low", int'(service_req), 0);
    tick();
    check("poll_after_ch2", int'(flag_address_3), 3);
    check("flag2_cleared", int'(rf[2]), 0);

    // Flags 0 and 3 visible while polling at 1: 3 wins, then 0.
    begin
      int k;
      k = 0;
      while (flag_address_3 != 2'd0 && k < 8) begin
        tick();
        k++;
      end
      check("poll_reaches_0", int'(flag_address_3), 0);
    end
    arrive(0);
    arrive(3);
    wait_req("wait_req_ch3");
    check("rr_first_ch3", int'(service_channel), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_req[%0d]", i), int'(service_req), 1);
      check($sformatf("hold_ch[%0d]", i), int'(service_channel), 3);
    end
    ack_once();
    wait_req("wait_req_ch0");
    check("rr_second_ch0", int'(service_channel), 0);
    ack_once();
    tick();

    // Arrival on the channel being cleared re-offers it.
    arrive(1);
    wait_req("wait_req_ch1");
    check("grant_ch1", int'(service_channel), 1);
    ack_once();
    rx_valid   = 1'b1;
    rx_channel = 2'd1;
    #1;
    check("conflict_rtr_we", int'(flag_rtr_write_enable), 0);
    check("conflict_rx_we", int'(flag_rx_write_enable), 1);
    tick();
    rx_valid = 1'b0;
    check("reoffer_req", int'(service_req), 1);
    check("reoffer_ch", int'(service_channel), 1);
    check("flag1_kept", int'(rf[1]), 1);
    ack_once();
    check("second_clear_rtr_we", int'(flag_rtr_write_enable), 1);
    check("second_clear_addr2", int'(flag_address_2), 1);
    tick();
    check("flag1_cleared", int'(rf[1]), 0);

    // Reset in the middle of a grant.
    arrive(2);
    wait_req("wait_req_reset");
    check("grant_before_reset", int'(service_req), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_req_drop", int'(service_req), 0);
    check("reset_rtr_low", int'(flag_rtr_write_enable), 0);
    check("reset_init_done_low", int'(init_done), 0);
    service_ack = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      service_ack = k[0];
      #1;
      check($sformatf("resweep_rtr_we[%0d]", k), int'(flag_rtr_write_enable), 1);
      check($sformatf("resweep_addr2[%0d]", k), int'(flag_address_2), k);
      tick();
    end
    check("resweep_done", int'(init_done), 1);
    for (int c = 0; c < N; c++) check($sformatf("resweep_flag[%0d]", c), int'(rf[c]), 0);
    for (int i = 0; i < 6; i++) begin
      service_ack = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("no_req_after_reset[%0d]", i), int'(service_req), 0);
    end
    service_ack = 1'b0;

    // Randomized arrivals and acks against the round-robin model.
    for (int c = 0; c < N; c++) m_pend[c] = 1'b0;
    m_next = 0;
    granted = 1'b0;
    just_acked = 1'b0;
    idle_cyc = 0;
    gch = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (service_req && !granted) begin
        exp_ch = first_pending();
        check("rr_grant", int'(service_channel), exp_ch);
        gch = (exp_ch < 0) ? int'(service_channel) : exp_ch;
        granted = 1'b1;
      end
      if (service_req || !any_pending()) idle_cyc = 0;
      else idle_cyc++;
      if (idle_cyc > 2 * N + 4) begin
        check("service_latency", idle_cyc, 2 * N + 4);
        idle_cyc = 0;
      end
      do_ack = service_req && granted && ($urandom_range(0, 2) == 0);
      do_rx  = !just_acked && (service_req || !any_pending()) && ($urandom_range(0, 1) == 1);
      ch     = int'($urandom_range(0, N - 1));
      rx_valid    = do_rx;
      rx_channel  = AW'(ch);
      service_ack = do_ack;
      tick();
      if (do_rx) m_pend[ch] = 1'b1;
      if (do_ack) begin
        m_pend[gch] = 1'b0;
        m_next = (gch + 1) % N;
        granted = 1'b0;
      end
      just_acked = do_ack;
    end
    rx_valid    = 1'b0;
    service_ack = 1'b0;
    if (just_acked) tick();
    for (int c = 0; c < N; c++) check($sformatf("final_flag[%0d]", c), int'(rf[c]), int'(m_pend[c]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
